// File: rtl/huffman_pkg.sv
// huffman_pkg
// Shared definitions for the Huffman table controller and decoder self-check:
// controller FSM encoding, {w, h, d} field positions inside a table word,
// the clear-to-load latency and the code-table entry validity rule.
package huffman_pkg;

  localparam int unsigned HUF_W     = 8;
  localparam int unsigned HUF_N_ENT = 16;
  localparam int unsigned HUF_AW    = 4;

  // Field index inside a table word; field f occupies bits [f*W +: W].
  localparam int unsigned FLD_D = 0;
  localparam int unsigned FLD_H = 1;
  localparam int unsigned FLD_W = 2;

  // Cycles from the new_conf pulse to the first table read.
  localparam int unsigned CLR_TO_LOAD = 2;

  // Width the validity rule works at; narrower fields are zero-extended.
  localparam int unsigned CHK_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_GAP   = 3'd2,
    ST_LOAD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  // An entry is usable when its width is 1..width and the code fits in it.
  function automatic logic entry_ok(input logic [CHK_W-1:0] w,
                                    input logic [CHK_W-1:0] h,
                                    input int unsigned      width);
    return (w != '0) && (w <= width) && ((h >> w) == '0);
  endfunction

endpackage

// File: rtl/huffman_entry_chk.sv
// huffman_entry_chk
// Combinational validity check of one code-table entry.
// Ports: w (code width), h (right-aligned code) -> ok (entry usable).
module huffman_entry_chk
  import huffman_pkg::*;
#(
  parameter int unsigned W = HUF_W
) (
  input  logic [W-1:0] w,
  input  logic [W-1:0] h,
  output logic         ok
);

  // Apply the shared rule at its fixed working width.
  always_comb begin
    ok = entry_ok(CHK_W'(w), CHK_W'(h), W);
  end

endmodule

// File: rtl/huffman_cfg_ctrl.sv
// huffman_cfg_ctrl
// Sequences one Huffman decoder: clears its table, streams entries from a
// table memory into its configuration port, then bridges a valid/ack byte
// source onto the decoder's d_req/en_in handshake.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, n_ent              (re)load request and entry count
//   tbl_rd, tbl_addr, tbl_data table memory (data one cycle after read)
//   new_conf, en_conf, d/h/w_conf  decoder configuration port
//   ready_in, d_req, d_in, en_in   decoder run handshake
//   src_valid, src_data, src_ack   coded-byte source
//   busy, cfg_done, cfg_err, word_cnt  status
module huffman_cfg_ctrl
  import huffman_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned N_ENT = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   n_ent,
  output logic          tbl_rd,
  output logic [AW-1:0] tbl_addr,
  input  logic [3*W-1:0] tbl_data,
  output logic          new_conf,
  output logic          en_conf,
  output logic [W-1:0]  d_conf,
  output logic [W-1:0]  h_conf,
  output logic [W-1:0]  w_conf,
  output logic          ready_in,
  input  logic          d_req,
  output logic [W-1:0]  d_in,
  output logic          en_in,
  input  logic          src_valid,
  input  logic [W-1:0]  src_data,
  output logic          src_ack,
  output logic          busy,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [15:0]   word_cnt
);

  localparam logic [AW:0] N_MAX = (AW+1)'(N_ENT);

  state_e        state_q, state_d;
  logic [AW:0]   n_eff_q, n_eff_d;
  logic [AW:0]   rc_q, rc_d;
  logic [1:0]    gc_q, gc_d;
  // rd_vld: tbl_data holds an entry this cycle; ent_vld: an entry is on the port.
  logic          rd_vld_q, rd_vld_d;
  logic          ent_vld_q, ent_vld_d;
  logic          tbl_rd_q, tbl_rd_d;
  logic [AW-1:0] tbl_addr_q, tbl_addr_d;
  logic          new_conf_q, new_conf_d;
  logic          en_conf_q, en_conf_d;
  logic [W-1:0]  d_conf_q, d_conf_d, h_conf_q, h_conf_d, w_conf_q, w_conf_d;
  logic          ready_in_q, ready_in_d;
  logic [W-1:0]  d_in_q, d_in_d;
  logic          en_in_q, en_in_d;
  logic          src_ack_q, src_ack_d;
  logic          busy_q, busy_d;
  logic          cfg_done_q, cfg_done_d;
  logic          cfg_err_q, cfg_err_d;
  logic [15:0]   word_cnt_q, word_cnt_d;

  logic [W-1:0]  ent_w, ent_h, ent_d;
  logic          ent_ok;
  logic          start_acc, rd_go, xfer;

  assign ent_w = tbl_data[FLD_W*W +: W];
  assign ent_h = tbl_data[FLD_H*W +: W];
  assign ent_d = tbl_data[FLD_D*W +: W];

  huffman_entry_chk #(.W(W)) u_entry_chk (
    .w  (ent_w),
    .h  (ent_h),
    .ok (ent_ok)
  );

  // Next-state logic of the sequencing FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CLR; else state_d = ST_IDLE;
      ST_CLR:   state_d = ST_GAP;
      ST_GAP:   if (gc_q == 2'd0) state_d = ST_LOAD; else state_d = ST_GAP;
      // Leave after the cycle showing the final entry (or at once when empty).
      ST_LOAD:  if ((n_eff_q == '0) || (ent_vld_q && !rd_vld_q)) state_d = ST_RUN;
                else state_d = ST_LOAD;
      ST_RUN:   if (start) state_d = ST_DRAIN; else state_d = ST_RUN;
      ST_DRAIN: state_d = ST_CLR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values, registered below.
  always_comb begin
    start_acc  = start && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    // Reads start from the last GAP cycle so address 0 lands in the first LOAD cycle.
    rd_go      = (((state_q == ST_GAP) && (gc_q == 2'd0)) || (state_q == ST_LOAD))
                 && (rc_q < n_eff_q);
    // A start in RUN blocks the transfer sampled on the same edge.
    xfer       = (state_q == ST_RUN) && !start && d_req && src_valid;

    n_eff_d    = n_eff_q;
    rc_d       = rc_q;
    gc_d       = gc_q;
    rd_vld_d   = tbl_rd_q;
    ent_vld_d  = rd_vld_q;
    tbl_rd_d   = 1'b0;
    tbl_addr_d = tbl_addr_q;
    new_conf_d = (state_d == ST_CLR);
    en_conf_d  = 1'b0;
    d_conf_d   = d_conf_q;
    h_conf_d   = h_conf_q;
    w_conf_d   = w_conf_q;
    ready_in_d = (state_d == ST_RUN);
    busy_d     = (state_d == ST_CLR) || (state_d == ST_GAP) ||
                 (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    d_in_d     = d_in_q;
    en_in_d    = 1'b0;
    src_ack_d  = 1'b0;
    cfg_done_d = cfg_done_q;
    cfg_err_d  = cfg_err_q;
    word_cnt_d = word_cnt_q;

    if (start_acc) begin
      n_eff_d = (n_ent > N_MAX) ? N_MAX : n_ent;
    end else begin
      n_eff_d = n_eff_q;
    end

    if (state_q == ST_CLR) begin
      rc_d = '0;
      gc_d = 2'(CLR_TO_LOAD - 2);
    end else if ((state_q == ST_GAP) && (gc_q != 2'd0)) begin
      gc_d = gc_q - 2'd1;
    end else begin
      gc_d = gc_q;
    end

    if (rd_go) begin
      tbl_rd_d   = 1'b1;
      tbl_addr_d = rc_q[AW-1:0];
      rc_d       = rc_q + (AW+1)'(1);
    end else begin
      tbl_rd_d   = 1'b0;
    end

    // Fields always follow the entry; only good entries raise en_conf.
    if (rd_vld_q) begin
      d_conf_d  = ent_d;
      h_conf_d  = ent_h;
      w_conf_d  = ent_w;
      en_conf_d = ent_ok;
    end else begin
      en_conf_d = 1'b0;
    end

    if (start_acc) begin
      cfg_done_d = 1'b0;
      cfg_err_d  = 1'b0;
      word_cnt_d = 16'd0;
    end else begin
      if ((state_q == ST_LOAD) && (state_d == ST_RUN)) cfg_done_d = 1'b1;
      else cfg_done_d = cfg_done_q;
      if (rd_vld_q && !ent_ok) cfg_err_d = 1'b1;
      else cfg_err_d = cfg_err_q;
      if (xfer) word_cnt_d = word_cnt_q + 16'd1;
      else word_cnt_d = word_cnt_q;
    end

    if (xfer) begin
      en_in_d   = 1'b1;
      src_ack_d = 1'b1;
      d_in_d    = src_data;
    end else begin
      en_in_d   = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_eff_q    <= '0;
      rc_q       <= '0;
      gc_q       <= 2'd0;
      rd_vld_q   <= 1'b0;
      ent_vld_q  <= 1'b0;
      tbl_rd_q   <= 1'b0;
      tbl_addr_q <= '0;
      new_conf_q <= 1'b0;
      en_conf_q  <= 1'b0;
      d_conf_q   <= '0;
      h_conf_q   <= '0;
      w_conf_q   <= '0;
      ready_in_q <= 1'b0;
      d_in_q     <= '0;
      en_in_q    <= 1'b0;
      src_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      n_eff_q    <= n_eff_d;
      rc_q       <= rc_d;
      gc_q       <= gc_d;
      rd_vld_q   <= rd_vld_d;
      ent_vld_q  <= ent_vld_d;
      tbl_rd_q   <= tbl_rd_d;
      tbl_addr_q <= tbl_addr_d;
      new_conf_q <= new_conf_d;
      en_conf_q  <= en_conf_d;
      d_conf_q   <= d_conf_d;
      h_conf_q   <= h_conf_d;
      w_conf_q   <= w_conf_d;
      ready_in_q <= ready_in_d;
      d_in_q     <= d_in_d;
      en_in_q    <= en_in_d;
      src_ack_q  <= src_ack_d;
      busy_q     <= busy_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign tbl_rd   = tbl_rd_q;
  assign tbl_addr = tbl_addr_q;
  assign new_conf = new_conf_q;
  assign en_conf  = en_conf_q;
  assign d_conf   = d_conf_q;
  assign h_conf   = h_conf_q;
  assign w_conf   = w_conf_q;
  assign ready_in = ready_in_q;
  assign d_in     = d_in_q;
  assign en_in    = en_in_q;
  assign src_ack  = src_ack_q;
  assign busy     = busy_q;
  assign cfg_done = cfg_done_q;
  assign cfg_err  = cfg_err_q;
  assign word_cnt = word_cnt_q;

endmodule
